// File: rtl/store_unit_if.sv
// -----------------------------------------------------------------------------
// store_unit_if -- Avalon-MM write-only bus bundle used by store_unit.
//
// Signals (little-endian, word addressed by byte address with [1:0] = 0):
//   address     [31:0]  word-aligned byte address of the write
//   write               write strobe, held with the rest of the bus while
//                       waitrequest is high
//   byteenable  [3:0]   active byte lanes, bit i enables writedata[8*i +: 8]
//   writedata   [31:0]  lane-replicated / shifted store data
//   waitrequest         slave back-pressure; the master holds the bus while high
//
// Modports:
//   master  drives address/write/byteenable/writedata, samples waitrequest
//   slave   samples the command signals, drives waitrequest
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface store_unit_if;
    logic [31:0] address;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;

    modport master (
        output address,
        output write,
        output byteenable,
        output writedata,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  write,
        input  byteenable,
        input  writedata,
        output waitrequest
    );
endinterface

// File: rtl/store_unit.sv
// -----------------------------------------------------------------------------
// store_unit -- MIPS-style store engine (SB/SH/SW and optional SWL/SWR) that
// turns a single CPU store request into one Avalon-MM write cycle.
//
// Ports:
//   clk         single clock, all state changes on the rising edge
//   reset       synchronous, active-high
//   start       store request, only sampled while idle
//   controls    [2:0] store kind: 000 SB, 010 SH, 101 SW, 110 SWL, 111 SWR
//   addr        [31:0] byte address of the store
//   data        [31:0] rt register value
//   busy        high whenever the FSM is not idle
//   done        one-cycle completion pulse
//   misaligned  qualifies done: the request was rejected and never hit the bus
//   bus         store_unit_if.master: address/write/byteenable/writedata out,
//               waitrequest in
//
// Behaviour summary:
//   IDLE --start, legal--> WRITE --!waitrequest--> DONE --> IDLE
//   IDLE --start, rejected--------------------->  DONE (misaligned=1)
//   A legal request shows write=1 one cycle after start and done one cycle
//   after the write is accepted. Every output is a flop.
//
// Configuration:
//   STORE_SWLR_EN  when defined, SWL (110) and SWR (111) are supported.
//                  Otherwise those codes are rejected like any invalid code.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  controls,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic        busy,
    output logic        done,
    output logic        misaligned,
    store_unit_if.master bus
);

    // -------------------------------------------------------------------------
    // Store kind encodings
    // -------------------------------------------------------------------------
    localparam logic [2:0] CtlSb  = 3'b000;
    localparam logic [2:0] CtlSh  = 3'b010;
    localparam logic [2:0] CtlSw  = 3'b101;
`ifdef STORE_SWLR_EN
    localparam logic [2:0] CtlSwl = 3'b110;
    localparam logic [2:0] CtlSwr = 3'b111;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Registered outputs and their next values
    logic [31:0] address_q, address_d;
    logic [31:0] writedata_q, writedata_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic        write_q, write_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        misaligned_q, misaligned_d;

    // Decoded request (combinational view of the current CPU inputs)
    logic        req_ok;
    logic [3:0]  lane_be;
    logic [31:0] lane_wd;
    logic [1:0]  k;

    assign k = addr[1:0];

`ifdef STORE_SWLR_EN
    // Byte-granular shift amounts: 8*k for SWR and 8*(3-k) for SWL.
    // For a 2-bit k, (3 - k) is simply ~k.
    logic [4:0] shl_amt;
    logic [4:0] shr_amt;

    assign shl_amt = {k, 3'b000};
    assign shr_amt = {~k, 3'b000};
`endif

    // -------------------------------------------------------------------------
    // Lane generation and legality check
    // -------------------------------------------------------------------------
    always_comb begin
        req_ok  = 1'b0;
        lane_be = 4'b0000;
        lane_wd = 32'h0000_0000;
        case (controls)
            CtlSb: begin
                req_ok  = 1'b1;
                lane_be = 4'b0001 << k;
                lane_wd = {4{data[7:0]}};
            end
            CtlSh: begin
                // Halfwords must sit on an even byte address.
                req_ok  = ~k[0];
                lane_be = k[1] ? 4'b1100 : 4'b0011;
                lane_wd = {2{data[15:0]}};
            end
            CtlSw: begin
                req_ok  = (k == 2'd0);
                lane_be = 4'b1111;
                lane_wd = data;
            end
`ifdef STORE_SWLR_EN
            CtlSwl: begin
                // Lanes 0..k carry the most significant bytes of rt.
                // For k=3 the shifted one falls off the top and wraps to 1111.
                req_ok  = 1'b1;
                lane_be = (4'b0010 << k) - 4'b0001;
                lane_wd = data >> shr_amt;
            end
            CtlSwr: begin
                // Lanes k..3 carry the least significant bytes of rt.
                req_ok  = 1'b1;
                lane_be = 4'b1111 << k;
                lane_wd = data << shl_amt;
            end
`endif
            default: begin
                req_ok = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            address_q    <= 32'h0000_0000;
            writedata_q  <= 32'h0000_0000;
            byteenable_q <= 4'b0000;
            write_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            write_q      <= write_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            misaligned_q <= misaligned_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = req_ok ? StWrite : StDone;
                end
            end
            StWrite: begin
                if (!bus.waitrequest) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // start is deliberately ignored here; the next request is
                // accepted in the idle cycle that follows.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: next values of the registered outputs. Outputs are derived
    // from state_d so that they line up with the state they describe.
    // -------------------------------------------------------------------------
    always_comb begin
        // address/writedata keep their last value outside a capture; the
        // strobe and lane enables fall to zero unless explicitly held.
        address_d    = address_q;
        writedata_d  = writedata_q;
        byteenable_d = 4'b0000;
        write_d      = 1'b0;
        misaligned_d = 1'b0;
        busy_d       = (state_d != StIdle);
        done_d       = (state_d == StDone);

        case (state_q)
            StIdle: begin
                if (start && req_ok) begin
                    address_d    = {addr[31:2], 2'b00};
                    byteenable_d = lane_be;
                    writedata_d  = lane_wd;
                    write_d      = 1'b1;
                end else if (start) begin
                    misaligned_d = 1'b1;
                end
            end
            StWrite: begin
                // Hold the whole command stable while the slave stalls.
                if (bus.waitrequest) begin
                    byteenable_d = byteenable_q;
                    write_d      = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output wiring
    // -------------------------------------------------------------------------
    assign busy           = busy_q;
    assign done           = done_q;
    assign misaligned     = misaligned_q;
    assign bus.address    = address_q;
    assign bus.write      = write_q;
    assign bus.byteenable = byteenable_q;
    assign bus.writedata  = writedata_q;

endmodule
